mem_wb_stage: RTL and testbench

//  MEM stage plus MEM/WB pipeline register of the 5-stage MIPS core. Sits directly

---
 rtl/cpu_pkg.sv | 19 +
 rtl/data_mem.sv | 39 +++
 rtl/mem_wb_stage.sv | 96 +++++++++
 tb/tb_mem_wb_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared control-field bit positions for the 5-stage MIPS core.
//               M   = {Branch, MemRead, MemWrite}
//               WB  = {RegWrite, MemToReg}
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

endpackage
`default_nettype wire

// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
// Module      : data_mem
// Description : Word-addressed data memory. Synchronous write port and
//               asynchronous read port sharing one address. The array has no
//               reset, so its contents survive a core reset.
// Ports       : clk   - rising-edge clock
//               we    - write enable (already qualified by the caller)
//               addr  - word index
//               wdata - write data
//               rdata - combinational read data (old word during a write)
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int c_DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [c_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    // The read sees the pre-edge contents, giving read-before-write ordering.
    assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM stage plus MEM/WB pipeline register. Resolves the branch,
//               performs the data-memory load/store and registers the values
//               consumed by the write-back mux.
// Ports       : clk, rst_n         - clock, async active-low reset
//               hold               - stall: freeze MEM/WB reg, block store
//               in_adder/in_alu/in_rd2/in_wreg/in_wb/in_m/in_zf
//                                  - EX/MEM buffer outputs
//               pc_src, branch_tgt - combinational branch decision/target
//               out_rdata/out_alu/out_wreg/out_wb/out_misalign
//                                  - registered MEM/WB outputs
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 256,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic [DATA_W-1:0] in_adder,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_rd2,
    input  logic [4:0]        in_wreg,
    input  logic [1:0]        in_wb,
    input  logic [2:0]        in_m,
    input  logic              in_zf,
    output logic              pc_src,
    output logic [DATA_W-1:0] branch_tgt,
    output logic [DATA_W-1:0] out_rdata,
    output logic [DATA_W-1:0] out_alu,
    output logic [4:0]        out_wreg,
    output logic [1:0]        out_wb,
    output logic              out_misalign
);

    logic              w_aligned;
    logic [ADDR_W-1:0] w_idx;
    logic              w_we;
    logic [DATA_W-1:0] w_mem_rdata;
    logic [DATA_W-1:0] w_rdata_next;
    logic              w_misalign_next;
    logic              w_unused;

    // Branch resolution is purely combinational and ignores hold.
    assign pc_src     = in_m[M_BRANCH] & in_zf;
    assign branch_tgt = in_adder;

    // Address bits above the word index are dropped, so accesses wrap
    // modulo MEM_WORDS*4 bytes.
    assign w_aligned = (in_alu[1:0] == 2'b00);
    assign w_idx     = in_alu[ADDR_W+1:2];

    // rst_n gates the enable so a reset asserted mid-cycle blocks the store.
    assign w_we = in_m[M_MEMWRITE] & w_aligned & ~hold & rst_n;

    data_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_data_mem (
        .clk   (clk),
        .we    (w_we),
        .addr  (w_idx),
        .wdata (in_rd2),
        .rdata (w_mem_rdata)
    );

    assign w_rdata_next    = (in_m[M_MEMREAD] & w_aligned) ? w_mem_rdata : '0;
    assign w_misalign_next = (in_m[M_MEMREAD] | in_m[M_MEMWRITE]) & ~w_aligned;

    // Ignored high address bits plus a depth/index-width consistency flag.
    assign w_unused = ^{in_alu[DATA_W-1:ADDR_W+2], (MEM_WORDS != (1 << ADDR_W))};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_rdata    <= '0;
            out_alu      <= '0;
            out_wreg     <= '0;
            out_wb       <= 2'b00;
            out_misalign <= 1'b0;
        end else if (!hold) begin
            out_rdata    <= w_rdata_next;
            out_alu      <= in_alu;
            out_wreg     <= in_wreg;
            out_wb       <= in_wb;
            out_misalign <= w_misalign_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Scoreboard bench for mem_wb_stage. A driver applies stimulus
//               on the falling edge and pushes the expected MEM/WB contents
//               computed by a behavioural memory model; a monitor pops and
//               compares after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    localparam int c_WORDS = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold;
    logic [31:0] in_adder, in_alu, in_rd2;
    logic [4:0]  in_wreg;
    logic [1:0]  in_wb;
    logic [2:0]  in_m;
    logic        in_zf;
    logic        pc_src;
    logic [31:0] branch_tgt, out_rdata, out_alu;
    logic [4:0]  out_wreg;
    logic [1:0]  out_wb;
    logic        out_misalign;

    mem_wb_stage #(.DATA_W(32), .MEM_WORDS(c_WORDS), .ADDR_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hold         (hold),
        .in_adder     (in_adder),
        .in_alu       (in_alu),
        .in_rd2       (in_rd2),
        .in_wreg      (in_wreg),
        .in_wb        (in_wb),
        .in_m         (in_m),
        .in_zf        (in_zf),
        .pc_src       (pc_src),
        .branch_tgt   (branch_tgt),
        .out_rdata    (out_rdata),
        .out_alu      (out_alu),
        .out_wreg     (out_wreg),
        .out_wb       (out_wb),
        .out_misalign (out_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] alu;
        logic [4:0]  wreg;
        logic [1:0]  wb;
        logic        mis;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;

    // Behavioural model: byte-addressed view of a 1 KiB wrapping memory.
    logic [31:0] mdl_mem [c_WORDS];
    exp_t        mdl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one set of inputs (no clock wait), check branch outputs, push the
    // register contents expected after the coming rising edge.
    task automatic drive_push(input logic h, input logic [31:0] adder, input logic [31:0] alu,
                              input logic [31:0] rd2, input logic [4:0] wreg,
                              input logic [1:0] wb, input logic [2:0] m, input logic zf);
        int          byte_addr;
        int          idx;
        bit          aligned;
        bit          rd, wr;
        logic [31:0] rdv;
        hold = h; in_adder = adder; in_alu = alu; in_rd2 = rd2;
        in_wreg = wreg; in_wb = wb; in_m = m; in_zf = zf;
        #1;
        chk("pc_src", {31'd0, pc_src}, {31'd0, m[2] && zf});
        chk("branch_tgt", branch_tgt, adder);
        byte_addr = int'(alu % 32'd1024);
        idx       = byte_addr / 4;
        aligned   = (byte_addr % 4) == 0;
        rd        = m[1];
        wr        = m[0];
        rdv       = (rd && aligned) ? mdl_mem[idx] : 32'd0;
        if (!h) begin
            mdl.rdata = rdv;
            mdl.alu   = alu;
            mdl.wreg  = wreg;
            mdl.wb    = wb;
            mdl.mis   = (rd || wr) && !aligned;
        end
        if (wr && aligned && !h) mdl_mem[idx] = rd2;
        q.push_back(mdl);
    endtask

    task automatic cycle(input logic h, input logic [31:0] adder, input logic [31:0] alu,
                         input logic [31:0] rd2, input logic [4:0] wreg,
                         input logic [1:0] wb, input logic [2:0] m, input logic zf);
        @(negedge clk);
        drive_push(h, adder, alu, rd2, wreg, wb, m, zf);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdata"}, out_rdata, 32'd0);
        chk({tag, "_alu"}, out_alu, 32'd0);
        chk({tag, "_wreg"}, {27'd0, out_wreg}, 32'd0);
        chk({tag, "_wb"}, {30'd0, out_wb}, 32'd0);
        chk({tag, "_mis"}, {31'd0, out_misalign}, 32'd0);
    endtask

    // Reset asserted mid-cycle while a store with RegWrite is on the inputs.
    task automatic reset_pulse(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        hold = 1'b0; in_alu = addr; in_rd2 = data; in_wb = 2'b11; in_m = 3'b001;
        in_wreg = 5'd9; in_adder = 32'd0; in_zf = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("rst_async");
        @(posedge clk);
        #2 chk("rst_hold_wb", {30'd0, out_wb}, 32'd0);
        @(negedge clk);
        mdl = '{rdata: 32'd0, alu: 32'd0, wreg: 5'd0, wb: 2'b00, mis: 1'b0};
        rst_n = 1'b1;
        drive_push(1'b0, 32'd0, addr, 32'd0, 5'd3, 2'b11, 3'b010, 1'b0);
        chk("rst_release_wb", {30'd0, out_wb}, 32'd0);
    endtask

    // Monitor: the DUT presents a new MEM/WB value after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out_rdata", out_rdata, e.rdata);
                chk("out_alu", out_alu, e.alu);
                chk("out_wreg", {27'd0, out_wreg}, {27'd0, e.wreg});
                chk("out_wb", {30'd0, out_wb}, {30'd0, e.wb});
                chk("out_misalign", {31'd0, out_misalign}, {31'd0, e.mis});
            end
        end
    end

    initial begin
        int budget;
        logic [31:0] a;
        rst_n = 1'b1; hold = 1'b0; in_adder = '0; in_alu = '0; in_rd2 = '0;
        in_wreg = '0; in_wb = 2'b11; in_m = 3'b000; in_zf = 1'b0;
        mdl = '{rdata: 32'd0, alu: 32'd0, wreg: 5'd0, wb: 2'b00, mis: 1'b0};

        // Power-on reset with RegWrite/MemToReg driven high.
        #1 rst_n = 1'b0;
        #1 chk_all_zero("por");
        @(negedge clk);
        rst_n = 1'b1;
        drive_push(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 2'b11, 3'b000, 1'b0);
        chk("por_release_wb", {30'd0, out_wb}, 32'd0);

        // Give every word a known value so loads are fully predictable.
        for (int i = 0; i < c_WORDS; i++)
            cycle(1'b0, 32'd0, i * 4, $urandom, 5'd0, 2'b00, 3'b001, 1'b0);

        // Store then load.
        cycle(1'b0, 32'd0, 32'h10, 32'hDEADBEEF, 5'd1, 2'b00, 3'b001, 1'b0);
        cycle(1'b0, 32'd0, 32'h10, 32'd0, 5'd2, 2'b11, 3'b010, 1'b0);

        // Branch taken / not taken.
        cycle(1'b0, 32'h40, 32'd0, 32'd0, 5'd0, 2'b00, 3'b100, 1'b1);
        cycle(1'b0, 32'h40, 32'd0, 32'd0, 5'd0, 2'b00, 3'b100, 1'b0);

        // Misaligned store/load, then address wrap onto word 4.
        cycle(1'b0, 32'd0, 32'h12, 32'hBAD0BAD0, 5'd4, 2'b00, 3'b001, 1'b0);
        cycle(1'b0, 32'd0, 32'h13, 32'd0, 5'd4, 2'b11, 3'b010, 1'b0);
        cycle(1'b0, 32'd0, 32'h10, 32'd0, 5'd4, 2'b11, 3'b010, 1'b0);
        cycle(1'b0, 32'd0, 32'h410, 32'hCAFEF00D, 5'd5, 2'b00, 3'b001, 1'b0);
        cycle(1'b0, 32'd0, 32'h10, 32'd0, 5'd6, 2'b11, 3'b010, 1'b0);

        // Hold freezes outputs and blocks the store; release performs it.
        cycle(1'b1, 32'd0, 32'h20, 32'h55, 5'd7, 2'b01, 3'b001, 1'b0);
        cycle(1'b1, 32'd0, 32'h24, 32'd0, 5'd8, 2'b11, 3'b010, 1'b0);
        cycle(1'b0, 32'd0, 32'h20, 32'h55, 5'd7, 2'b01, 3'b001, 1'b0);
        cycle(1'b0, 32'd0, 32'h20, 32'd0, 5'd8, 2'b11, 3'b010, 1'b0);

        // Read and write in the same cycle: old word returned.
        cycle(1'b0, 32'd0, 32'h30, 32'h1111, 5'd0, 2'b00, 3'b001, 1'b0);
        cycle(1'b0, 32'd0, 32'h30, 32'h2222, 5'd9, 2'b11, 3'b011, 1'b0);
        cycle(1'b0, 32'd0, 32'h30, 32'd0, 5'd9, 2'b11, 3'b010, 1'b0);

        // Mid-cycle reset blocks the store and clears the pipeline register.
        reset_pulse(32'h30, 32'h0BADCAFE);

        // Randomized traffic over a small window to force address reuse.
        for (int i = 0; i < 400; i++) begin
            a = {$urandom_range(0, 3) == 0 ? $urandom : 32'd0, 2'b00} ^
                {24'd0, 4'($urandom_range(0, 15)), 4'd0};
            a[3:2] = 2'($urandom);
            if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
            cycle($urandom_range(0, 6) == 0, $urandom, a, $urandom, 5'($urandom),
                  2'($urandom), 3'($urandom), 1'($urandom));
        end

        @(negedge clk);
        budget = 20;
        while (q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
